motor_lona: RTL and testbench

MOTOR_LONA -- requirements
Module: motor_lona

---
 rtl/motor_lona_pkg.sv | 20 ++
 rtl/motor_lona_tempo.sv | 23 ++
 rtl/motor_lona.sv | 108 ++++++++++
 tb/tb_motor_lona.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/motor_lona_pkg.sv
// Shared types and constants for the awning motor controller (motor_lona).
package motor_lona_pkg;

  typedef enum logic [2:0] {
    PARADO,
    FECHANDO,
    ABRINDO,
    PAUSA,
    FALHA
  } state_t;

  // {A,B} command encoding
  localparam logic [1:0] CMD_PARA   = 2'b00;
  localparam logic [1:0] CMD_FECHA  = 2'b10;
  localparam logic [1:0] CMD_ABRE   = 2'b01;
  localparam logic [1:0] CMD_ILEGAL = 2'b11;

  localparam int STALL_TH = 4;

endpackage

// File: rtl/motor_lona_tempo.sv
// Dead-time down-counter: load presets the count, tick decrements, done when zero.
module motor_lona_tempo #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] val,
  input  logic         tick,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  cnt <= '0;
    else if (load)               cnt <= val;
    else if (tick && cnt != '0)  cnt <= cnt - 1'b1;
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/motor_lona.sv
// Awning motor controller: position tracking, end stops, reversal dead time, fault.
// Optional stall detection at the end stops is enabled by MOTOR_LONA_STALL_EN.
module motor_lona
  import motor_lona_pkg::*;
#(
  parameter int TRAVEL   = 16,
  parameter int DEADTIME = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       A,
  input  logic       B,
  output logic       Fe,
  output logic       Fd,
  output logic [7:0] pos,
  output logic       moving,
  output logic       fault,
  output logic       stall
);

  localparam logic [7:0] TRAV    = TRAVEL[7:0];
  // Counter is preloaded one short so that PAUSA lasts exactly DEADTIME cycles
  localparam logic [3:0] DT_LOAD = 4'(DEADTIME - 1);

  state_t     state;
  logic [1:0] cmd;
  logic       dt_load, dt_done;

  assign cmd = {A, B};

  assign dt_load = (state == FECHANDO && cmd == CMD_ABRE) ||
                   (state == ABRINDO  && cmd == CMD_FECHA);

  motor_lona_tempo #(.W(4)) u_tempo (
    .clk  (clk),
    .rst_n(rst_n),
    .load (dt_load),
    .val  (DT_LOAD),
    .tick (state == PAUSA),
    .done (dt_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= PARADO;
      pos   <= '0;
    end else if (cmd == CMD_ILEGAL) begin
      state <= FALHA;
    end else begin
      case (state)
        PARADO, PAUSA: begin
          if (state == PARADO || dt_done) begin
            if (cmd == CMD_FECHA && pos < TRAV)       state <= FECHANDO;
            else if (cmd == CMD_ABRE && pos != '0)    state <= ABRINDO;
            else                                      state <= PARADO;
          end
        end
        FECHANDO: begin
          if (cmd == CMD_PARA)      state <= PARADO;
          else if (cmd == CMD_ABRE) state <= PAUSA;
          else if (pos < TRAV) begin
            pos <= pos + 8'd1;
            if (pos == TRAV - 8'd1) state <= PARADO;
          end else                  state <= PARADO;
        end
        ABRINDO: begin
          if (cmd == CMD_PARA)       state <= PARADO;
          else if (cmd == CMD_FECHA) state <= PAUSA;
          else if (pos != '0) begin
            pos <= pos - 8'd1;
            if (pos == 8'd1) state <= PARADO;
          end else                   state <= PARADO;
        end
        FALHA:   if (cmd == CMD_PARA) state <= PARADO;
        default: state <= PARADO;
      endcase
    end
  end

  assign Fe     = (pos == TRAV);
  assign Fd     = (pos == '0);
  assign moving = (state == FECHANDO) || (state == ABRINDO);
  assign fault  = (state == FALHA);

`ifdef MOTOR_LONA_STALL_EN
  logic [2:0] stall_cnt;
  logic       pushing;

  // Pushing into a stop keeps the command constant, so losing the condition means the command changed
  assign pushing = (cmd == CMD_FECHA && Fe) || (cmd == CMD_ABRE && Fd);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      stall     <= 1'b0;
    end else if (pushing) begin
      if (stall_cnt != 3'(STALL_TH)) stall_cnt <= stall_cnt + 3'd1;
      if (stall_cnt == 3'(STALL_TH - 1)) stall <= 1'b1;
    end else begin
      stall_cnt <= '0;
      stall     <= 1'b0;
    end
  end
`else
  assign stall = 1'b0;
`endif

endmodule

// File: tb/tb_motor_lona.sv
// Directed self-checking bench for motor_lona (TRAVEL=16, DEADTIME=2).
module tb_motor_lona;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       A = 1'b0, B = 1'b0;
  logic       Fe, Fd, moving, fault, stall;
  logic [7:0] pos;

  int n_cmp = 0;
  int n_bad = 0;

  motor_lona #(.TRAVEL(16), .DEADTIME(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .A     (A),
    .B     (B),
    .Fe    (Fe),
    .Fd    (Fd),
    .pos   (pos),
    .moving(moving),
    .fault (fault),
    .stall (stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp_v);
    end
  endtask

  // inputs change and outputs are sampled on the falling edge
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; {A, B} = 2'b00;
    step(1);
    rst_n = 1'b1;
  endtask

  initial begin
    #1;
    chk("rst_pos", pos, 0);
    chk("rst_fd", Fd, 1);
    chk("rst_fe", Fe, 0);
    chk("rst_moving", moving, 0);
    chk("rst_fault", fault, 0);
    chk("rst_stall", stall, 0);
    step(1);
    rst_n = 1'b1;

    // full close: 1-cycle latency, then pos 1..16, stop at TRAVEL
    {A, B} = 2'b10;
    step(1);
    chk("close_start_pos", pos, 0);
    chk("close_start_moving", moving, 1);
    for (int k = 1; k <= 16; k++) begin
      step(1);
      chk("close_pos", pos, k);
      chk("close_fe", Fe, (k == 16));
    end
    chk("close_end_moving", moving, 0);
    step(3);
    chk("close_hold_pos", pos, 16);
    chk("close_hold_fe", Fe, 1);
    chk("close_hold_fd", Fd, 0);
    chk("close_hold_moving", moving, 0);

    // reversal at pos=5: two stopped cycles, then opening
    do_reset();
    {A, B} = 2'b10;
    step(6);
    chk("rev_pre_pos", pos, 5);
    {A, B} = 2'b01;
    step(1);
    chk("rev_pause1_pos", pos, 5);
    chk("rev_pause1_moving", moving, 0);
    step(1);
    chk("rev_pause2_pos", pos, 5);
    chk("rev_pause2_moving", moving, 0);
    step(1);
    chk("rev_open_pos", pos, 5);
    chk("rev_open_moving", moving, 1);
    step(1);
    chk("rev_dec_pos", pos, 4);

    // illegal command while opening at pos=8
    do_reset();
    {A, B} = 2'b10;
    step(9);
    {A, B} = 2'b01;
    step(3);
    chk("flt_pre_pos", pos, 8);
    chk("flt_pre_moving", moving, 1);
    {A, B} = 2'b11;
    step(1);
    chk("flt_fault", fault, 1);
    chk("flt_pos", pos, 8);
    chk("flt_moving", moving, 0);
    {A, B} = 2'b10;
    step(2);
    chk("flt_ign_fault", fault, 1);
    chk("flt_ign_pos", pos, 8);
    {A, B} = 2'b00;
    step(1);
    chk("flt_clr_fault", fault, 0);
    {A, B} = 2'b10;
    step(2);
    chk("flt_resume_pos", pos, 9);

    // asynchronous reset mid-travel at pos=10
    do_reset();
    {A, B} = 2'b10;
    step(11);
    chk("ares_pre_pos", pos, 10);
    #2 rst_n = 1'b0;
    #1;
    chk("ares_pos", pos, 0);
    chk("ares_fd", Fd, 1);
    chk("ares_fe", Fe, 0);
    chk("ares_moving", moving, 0);
    step(1);
    rst_n = 1'b1;
    step(1);
    chk("ares_restart_pos", pos, 0);
    chk("ares_restart_moving", moving, 1);
    step(1);
    chk("ares_step_pos", pos, 1);

    // driving open against the open stop
    do_reset();
    {A, B} = 2'b01;
    step(3);
    chk("stall_c3", stall, 0);
    chk("stall_pos", pos, 0);
    chk("stall_moving", moving, 0);
    step(1);
`ifdef MOTOR_LONA_STALL_EN
    chk("stall_c4", stall, 1);
`else
    chk("stall_c4", stall, 0);
`endif
    {A, B} = 2'b00;
    step(1);
    chk("stall_clr", stall, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
